// File: rtl/wb_retire_queue.sv
// wb_retire_queue: writeback-stage retire queue.
// Buffers completed instructions from the memory stage in a circular queue,
// retires the head to the register file / CSR file / trace port at one
// instruction per cycle, resolves exception and ertn flushes at the head,
// and offers combinational bypass lookups into the pending entries.
//
// Handshake: an instruction transfers on a rising clk edge when
// ms_to_ws_valid && ws_allowin are both high. ws_allowin is computed from
// registered state only (never from ms_to_ws_valid), so the producer may
// hold valid high and wait; a held instruction stays stable until accepted.
module wb_retire_queue #(
    parameter int DEPTH     = 4,
    parameter int FWD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         ms_to_ws_valid,
    output logic                         ws_allowin,
    input  logic [31:0]                  ms_pc,
    input  logic [31:0]                  ms_result,
    input  logic                         ms_gr_we,
    input  logic [4:0]                   ms_dest,
    input  logic [6:0]                   ms_excp_num,
    input  logic [31:0]                  ms_bad_va,
    input  logic                         ms_ertn,
    input  logic                         ms_csr_we,
    input  logic [13:0]                  ms_csr_idx,
    input  logic [31:0]                  ms_csr_wdata,

    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [31:0]                  rf_wdata,

    input  logic [5*FWD_PORTS-1:0]       fwd_raddr,
    output logic [FWD_PORTS-1:0]         fwd_hit,
    output logic [32*FWD_PORTS-1:0]      fwd_data,

    output logic                         excp_flush,
    output logic                         ertn_flush,
    output logic [31:0]                  csr_era,
    output logic [5:0]                   csr_ecode,
    output logic [8:0]                   csr_esubcode,
    output logic                         va_error,
    output logic [31:0]                  bad_va,
    output logic                         csr_wr_en,
    output logic [13:0]                  wr_csr_addr,
    output logic [31:0]                  wr_csr_data,

    output logic [$clog2(DEPTH+1)-1:0]   occupancy,

    output logic [31:0]                  debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_we,
    output logic [4:0]                   debug_wb_rf_wnum,
    output logic [31:0]                  debug_wb_rf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Exception codes (LoongArch encoding).
    localparam logic [5:0] ECODE_INT     = 6'h00;
    localparam logic [5:0] ECODE_ADEF    = 6'h08;
    localparam logic [5:0] ECODE_ALE     = 6'h09;
    localparam logic [5:0] ECODE_SYS     = 6'h0B;
    localparam logic [5:0] ECODE_BRK     = 6'h0C;
    localparam logic [5:0] ECODE_INE     = 6'h0D;
    localparam logic [5:0] ECODE_IPE     = 6'h0E;
    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

    // Exception flag bit positions within excp_num.
    localparam int EX_INT  = 0;
    localparam int EX_ADEF = 1;
    localparam int EX_SYS  = 2;
    localparam int EX_BRK  = 3;
    localparam int EX_INE  = 4;
    localparam int EX_IPE  = 5;
    localparam int EX_ALE  = 6;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic        gr_we;
        logic [4:0]  dest;
        logic [6:0]  excp;
        logic [31:0] bad_va;
        logic        ertn;
        logic        csr_we;
        logic [13:0] csr_idx;
        logic [31:0] csr_wdata;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    entry_t             ms_ent;
    entry_t             head_ent;
    logic               head_vld;
    logic               head_excp;
    logic               head_ertn;
    logic               flush;
    logic               retire;
    logic               enq;

    logic [4:0]         lk_raddr;
    logic [PTR_W-1:0]   lk_idx;

    // Pack the incoming instruction into a queue entry.
    always_comb begin
        ms_ent           = '0;
        ms_ent.pc        = ms_pc;
        ms_ent.result    = ms_result;
        ms_ent.gr_we     = ms_gr_we;
        ms_ent.dest      = ms_dest;
        ms_ent.excp      = ms_excp_num;
        ms_ent.bad_va    = ms_bad_va;
        ms_ent.ertn      = ms_ertn;
        ms_ent.csr_we    = ms_csr_we;
        ms_ent.csr_idx   = ms_csr_idx;
        ms_ent.csr_wdata = ms_csr_wdata;
    end

    // Classify the head: normal retire, exception flush or ertn flush.
    always_comb begin
        head_ent   = ent_q[head_q];
        head_vld   = (count_q != '0) && valid_q[head_q];
        head_excp  = head_vld && (head_ent.excp != '0);
        head_ertn  = head_vld && head_ent.ertn && (head_ent.excp == '0);
        flush      = head_excp || head_ertn;
        retire     = head_vld && !flush;
        // A full queue refuses entries even while its head is retiring.
        ws_allowin = (count_q < CNT_W'(DEPTH)) && !flush;
        enq        = ms_to_ws_valid && ws_allowin;
    end

    // Next queue state: a flush empties everything and drops any enqueue.
    always_comb begin
        ent_d   = ent_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (retire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + 1'b1;
            end
            if (enq) begin
                ent_d[tail_q]   = ms_ent;
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + 1'b1;
            end
            case ({enq, retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q   <= '{default: '0};
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Register-file, CSR-file and trace outputs driven from the head.
    always_comb begin
        rf_we             = retire && head_ent.gr_we;
        rf_waddr          = retire ? head_ent.dest   : 5'd0;
        rf_wdata          = retire ? head_ent.result : 32'd0;
        csr_wr_en         = retire && head_ent.csr_we;
        wr_csr_addr       = retire ? head_ent.csr_idx   : 14'd0;
        wr_csr_data       = retire ? head_ent.csr_wdata : 32'd0;
        excp_flush        = head_excp;
        ertn_flush        = head_ertn;
        csr_era           = head_vld ? head_ent.pc : 32'd0;
        debug_wb_pc       = head_vld ? head_ent.pc : 32'd0;
        debug_wb_rf_we    = {4{rf_we}};
        debug_wb_rf_wnum  = head_vld ? head_ent.dest   : 5'd0;
        debug_wb_rf_wdata = head_vld ? head_ent.result : 32'd0;
        occupancy         = count_q;
    end

    // Exception cause decode, lowest flag bit has highest priority.
    always_comb begin
        csr_ecode    = 6'd0;
        csr_esubcode = 9'd0;
        va_error     = 1'b0;
        bad_va       = 32'd0;
        if (head_excp) begin
            if (head_ent.excp[EX_INT]) begin
                csr_ecode = ECODE_INT;
            end else if (head_ent.excp[EX_ADEF]) begin
                csr_ecode    = ECODE_ADEF;
                csr_esubcode = ESUBCODE_ADEF;
                va_error     = 1'b1;
                bad_va       = head_ent.pc;
            end else if (head_ent.excp[EX_SYS]) begin
                csr_ecode = ECODE_SYS;
            end else if (head_ent.excp[EX_BRK]) begin
                csr_ecode = ECODE_BRK;
            end else if (head_ent.excp[EX_INE]) begin
                csr_ecode = ECODE_INE;
            end else if (head_ent.excp[EX_IPE]) begin
                csr_ecode = ECODE_IPE;
            end else if (head_ent.excp[EX_ALE]) begin
                csr_ecode = ECODE_ALE;
                va_error  = 1'b1;
                bad_va    = head_ent.bad_va;
            end
        end
    end

    // Bypass lookup: walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        lk_raddr = '0;
        lk_idx   = '0;
        for (int p = 0; p < FWD_PORTS; p++) begin
            lk_raddr = fwd_raddr[p*5 +: 5];
            for (int i = 0; i < DEPTH; i++) begin
                lk_idx = head_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && valid_q[lk_idx] &&
                    ent_q[lk_idx].gr_we && (ent_q[lk_idx].excp == '0) &&
                    (lk_raddr != 5'd0) && (ent_q[lk_idx].dest == lk_raddr)) begin
                    fwd_hit[p]            = 1'b1;
                    fwd_data[p*32 +: 32]  = ent_q[lk_idx].result;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: directed instruction streams, a queue-level
// reference model compared on every falling edge, a retire-order
// scoreboard, and literal expectations at key points of each scenario.
module tb_wb_retire_queue;

    localparam int DEPTH     = 4;
    localparam int FWD_PORTS = 2;

    logic        clk;
    logic        rst;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [31:0] ms_result;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [6:0]  ms_excp_num;
    logic [31:0] ms_bad_va;
    logic        ms_ertn;
    logic        ms_csr_we;
    logic [13:0] ms_csr_idx;
    logic [31:0] ms_csr_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [9:0]  fwd_raddr;
    logic [1:0]  fwd_hit;
    logic [63:0] fwd_data;
    logic        excp_flush;
    logic        ertn_flush;
    logic [31:0] csr_era;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic        va_error;
    logic [31:0] bad_va;
    logic        csr_wr_en;
    logic [13:0] wr_csr_addr;
    logic [31:0] wr_csr_data;
    logic [2:0]  occupancy;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int n_checks = 0;
    int n_errors = 0;

    wb_retire_queue #(.DEPTH(DEPTH), .FWD_PORTS(FWD_PORTS)) dut (
        .clk(clk), .reset(rst),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_gr_we(ms_gr_we),
        .ms_dest(ms_dest), .ms_excp_num(ms_excp_num), .ms_bad_va(ms_bad_va),
        .ms_ertn(ms_ertn), .ms_csr_we(ms_csr_we), .ms_csr_idx(ms_csr_idx),
        .ms_csr_wdata(ms_csr_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush), .csr_era(csr_era),
        .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .va_error(va_error), .bad_va(bad_va),
        .csr_wr_en(csr_wr_en), .wr_csr_addr(wr_csr_addr), .wr_csr_data(wr_csr_data),
        .occupancy(occupancy),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- common check ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic        gr_we;
        logic [4:0]  dest;
        logic [6:0]  excp;
        logic [31:0] bad_va;
        logic        ertn;
        logic        csr_we;
        logic [13:0] csr_idx;
        logic [31:0] csr_wdata;
    } ins_t;

    ins_t mq[$];                  // instructions held, oldest first
    logic [31:0] exp_q[$];        // PCs expected to retire with a GPR write, in order

    function automatic logic [5:0] ecode_for(input int b);
        case (b)
            0:       return 6'h00;
            1:       return 6'h08;
            2:       return 6'h0B;
            3:       return 6'h0C;
            4:       return 6'h0D;
            5:       return 6'h0E;
            default: return 6'h09;
        endcase
    endfunction

    // Queue-level update at each clock edge: a flagged head empties the queue,
    // otherwise the head leaves and an offered instruction joins if there was room.
    task automatic model_step();
        int   n;
        logic fl;
        logic allow;
        ins_t ni;
        n  = mq.size();
        fl = 1'b0;
        if (n > 0) fl = (mq[0].excp != 7'd0) || mq[0].ertn;
        allow = (n < DEPTH) && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            if (n > 0) ni = mq.pop_front();
            if (ms_to_ws_valid && allow) begin
                ni.pc = ms_pc; ni.result = ms_result; ni.gr_we = ms_gr_we;
                ni.dest = ms_dest; ni.excp = ms_excp_num; ni.bad_va = ms_bad_va;
                ni.ertn = ms_ertn; ni.csr_we = ms_csr_we; ni.csr_idx = ms_csr_idx;
                ni.csr_wdata = ms_csr_wdata;
                mq.push_back(ni);
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) mq.delete();
        else     model_step();
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        int          n;
        ins_t        h;
        logic        e_allow, e_rf_we, e_xf, e_ef, e_va, e_cwe, fl, found;
        logic [4:0]  e_waddr, e_wnum, ra;
        logic [31:0] e_wdata, e_era, e_bva, e_caddr, e_cdata, e_dpc, e_dwd;
        logic [5:0]  e_ecode;
        logic [1:0]  e_hit;
        logic [31:0] e_fd [2];
        n = mq.size();
        e_rf_we = 0; e_waddr = 0; e_wdata = 0; e_xf = 0; e_ef = 0; e_va = 0;
        e_cwe = 0; e_caddr = 0; e_cdata = 0; e_era = 0; e_bva = 0; e_ecode = 0;
        e_dpc = 0; e_wnum = 0; e_dwd = 0; fl = 0; found = 0;
        e_hit = 0; e_fd[0] = 0; e_fd[1] = 0;
        if (n > 0) begin
            h = mq[0];
            e_era = h.pc; e_dpc = h.pc; e_wnum = h.dest; e_dwd = h.result;
            if (h.excp != 0) begin
                e_xf = 1; fl = 1;
                for (int b = 0; b < 7; b++) begin
                    if (h.excp[b] && !found) begin
                        found = 1;
                        e_ecode = ecode_for(b);
                        if (b == 1) begin e_va = 1; e_bva = h.pc; end
                        if (b == 6) begin e_va = 1; e_bva = h.bad_va; end
                    end
                end
            end else if (h.ertn) begin
                e_ef = 1; fl = 1;
            end else begin
                e_rf_we = h.gr_we; e_waddr = h.dest; e_wdata = h.result;
                e_cwe = h.csr_we; e_caddr = 32'(h.csr_idx); e_cdata = h.csr_wdata;
            end
        end
        e_allow = (n < DEPTH) && !fl;
        for (int p = 0; p < FWD_PORTS; p++) begin
            ra = fwd_raddr[p*5 +: 5];
            for (int k = n - 1; k >= 0; k--) begin
                if (!e_hit[p] && ra != 0 && mq[k].gr_we && mq[k].excp == 0 && mq[k].dest == ra) begin
                    e_hit[p] = 1;
                    e_fd[p]  = mq[k].result;
                end
            end
        end
        chk("m_allowin",  32'(ws_allowin),   32'(e_allow));
        chk("m_rf_we",    32'(rf_we),        32'(e_rf_we));
        chk("m_rf_waddr", 32'(rf_waddr),     32'(e_waddr));
        chk("m_rf_wdata", rf_wdata,          e_wdata);
        chk("m_excp_fl",  32'(excp_flush),   32'(e_xf));
        chk("m_ertn_fl",  32'(ertn_flush),   32'(e_ef));
        chk("m_era",      csr_era,           e_era);
        chk("m_ecode",    32'(csr_ecode),    32'(e_ecode));
        chk("m_esubcode", 32'(csr_esubcode), 32'd0);
        chk("m_va_error", 32'(va_error),     32'(e_va));
        chk("m_bad_va",   bad_va,            e_bva);
        chk("m_csr_we",   32'(csr_wr_en),    32'(e_cwe));
        chk("m_csr_addr", 32'(wr_csr_addr),  e_caddr);
        chk("m_csr_data", wr_csr_data,       e_cdata);
        chk("m_occ",      32'(occupancy),    32'(n));
        chk("m_dbg_pc",   debug_wb_pc,       e_dpc);
        chk("m_dbg_we",   32'(debug_wb_rf_we), 32'({4{e_rf_we}}));
        chk("m_dbg_wnum", 32'(debug_wb_rf_wnum), 32'(e_wnum));
        chk("m_dbg_wd",   debug_wb_rf_wdata, e_dwd);
        chk("m_fwd_hit",  32'(fwd_hit),      32'(e_hit));
        chk("m_fwd_d0",   fwd_data[31:0],    e_fd[0]);
        chk("m_fwd_d1",   fwd_data[63:32],   e_fd[1]);
        // Retire-order scoreboard on the trace port.
        if (!rst && debug_wb_rf_we != 4'd0) begin
            if (exp_q.size() == 0) chk("sb_unexpected_retire", debug_wb_pc, 32'hffffffff);
            else                   chk("sb_retire_pc", debug_wb_pc, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ms_to_ws_valid = 0; ms_pc = 0; ms_result = 0; ms_gr_we = 0; ms_dest = 0;
        ms_excp_num = 0; ms_bad_va = 0; ms_ertn = 0; ms_csr_we = 0;
        ms_csr_idx = 0; ms_csr_wdata = 0;
    endtask

    task automatic set_ins(input logic [31:0] pc, input logic [31:0] res,
                           input logic gwe, input logic [4:0] dst,
                           input logic [6:0] ex, input logic [31:0] bva,
                           input logic er, input logic cwe,
                           input logic [13:0] cidx, input logic [31:0] cwd);
        ms_to_ws_valid = 1; ms_pc = pc; ms_result = res; ms_gr_we = gwe;
        ms_dest = dst; ms_excp_num = ex; ms_bad_va = bva; ms_ertn = er;
        ms_csr_we = cwe; ms_csr_idx = cidx; ms_csr_wdata = cwd;
    endtask

    // A normal GPR-writing instruction that must later retire.
    task automatic push_alu(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dst);
        set_ins(pc, res, 1'b1, dst, 7'd0, 32'd0, 1'b0, 1'b0, 14'd0, 32'd0);
        exp_q.push_back(pc);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 0;
        fwd_raddr = 0;
        idle();
        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_allowin", 32'(ws_allowin), 32'd1);
        chk("reset_occ", 32'(occupancy), 32'd0);
        chk("reset_dbg_pc", debug_wb_pc, 32'd0);
        rst = 0;
        step();

        // Three back-to-back ALU instructions retire in order.
        push_alu(32'h1c000000, 32'h11, 5'd1); step();
        chk("alu0_rf_we", 32'(rf_we), 32'd1);
        chk("alu0_waddr", 32'(rf_waddr), 32'd1);
        chk("alu0_wdata", rf_wdata, 32'h11);
        chk("alu0_occ", 32'(occupancy), 32'd1);
        push_alu(32'h1c000004, 32'h22, 5'd2); step();
        chk("alu1_wdata", rf_wdata, 32'h22);
        chk("alu1_pc", debug_wb_pc, 32'h1c000004);
        push_alu(32'h1c000008, 32'h33, 5'd3); step();
        chk("alu2_wdata", rf_wdata, 32'h33);
        chk("alu2_waddr", 32'(rf_waddr), 32'd3);
        idle(); step();
        chk("alu_done_occ", 32'(occupancy), 32'd0);
        chk("alu_done_we", 32'(rf_we), 32'd0);

        // Six-cycle burst: allowin never drops, each PC retires once.
        for (int i = 0; i < 6; i++) begin
            push_alu(32'h1c000040 + 32'(4*i), 32'h100 + 32'(i), 5'(4 + i));
            step();
            chk("burst_allowin", 32'(ws_allowin), 32'd1);
        end
        idle(); step();
        chk("burst_drained", 32'(exp_q.size()), 32'd0);

        // CSR write with no GPR write.
        set_ins(32'h1c000080, 32'h0, 1'b0, 5'd0, 7'd0, 32'd0, 1'b0, 1'b1, 14'h0006, 32'hdead0001);
        step();
        chk("csr_we", 32'(csr_wr_en), 32'd1);
        chk("csr_addr", 32'(wr_csr_addr), 32'h6);
        chk("csr_data", wr_csr_data, 32'hdead0001);
        chk("csr_rf_we", 32'(rf_we), 32'd0);
        idle(); step();

        // ALE store flushes; the younger instruction offered meanwhile is dropped.
        fwd_raddr = {5'd0, 5'd7};
        set_ins(32'h1c000100, 32'h77, 1'b1, 5'd7, 7'b1000000, 32'h00000103, 1'b0, 1'b0, 14'd0, 32'd0);
        step();
        chk("ale_flush", 32'(excp_flush), 32'd1);
        chk("ale_ecode", 32'(csr_ecode), 32'h09);
        chk("ale_va_error", 32'(va_error), 32'd1);
        chk("ale_bad_va", bad_va, 32'h00000103);
        chk("ale_rf_we", 32'(rf_we), 32'd0);
        chk("ale_dbg_pc", debug_wb_pc, 32'h1c000100);
        chk("ale_dbg_we", 32'(debug_wb_rf_we), 32'd0);
        chk("ale_allowin", 32'(ws_allowin), 32'd0);
        chk("ale_no_fwd", 32'(fwd_hit), 32'd0);
        set_ins(32'h1c000104, 32'h88, 1'b1, 5'd8, 7'd0, 32'd0, 1'b0, 1'b0, 14'd0, 32'd0);
        step();
        chk("ale_after_occ", 32'(occupancy), 32'd0);
        chk("ale_after_we", 32'(rf_we), 32'd0);
        chk("ale_after_flush", 32'(excp_flush), 32'd0);
        idle(); step();
        chk("ale_young_gone", 32'(occupancy), 32'd0);
        fwd_raddr = 0;

        // ADEF together with ertn: the exception wins.
        set_ins(32'h1c000200, 32'h0, 1'b0, 5'd0, 7'b0000010, 32'h0000ffff, 1'b1, 1'b0, 14'd0, 32'd0);
        step();
        chk("adef_excp_flush", 32'(excp_flush), 32'd1);
        chk("adef_ertn_flush", 32'(ertn_flush), 32'd0);
        chk("adef_ecode", 32'(csr_ecode), 32'h08);
        chk("adef_esub", 32'(csr_esubcode), 32'h000);
        chk("adef_bad_va", bad_va, 32'h1c000200);
        chk("adef_era", csr_era, 32'h1c000200);
        idle(); step();

        // ertn alone.
        set_ins(32'h1c000300, 32'h0, 1'b0, 5'd0, 7'd0, 32'd0, 1'b1, 1'b0, 14'd0, 32'd0);
        step();
        chk("ertn_flush", 32'(ertn_flush), 32'd1);
        chk("ertn_excp", 32'(excp_flush), 32'd0);
        chk("ertn_va", 32'(va_error), 32'd0);
        idle(); step();
        chk("ertn_after_occ", 32'(occupancy), 32'd0);

        // Priority with several flags: SYS beats ALE, INT beats everything.
        set_ins(32'h1c000310, 32'h0, 1'b0, 5'd0, 7'b1000100, 32'h00000555, 1'b0, 1'b0, 14'd0, 32'd0);
        step();
        chk("sys_ecode", 32'(csr_ecode), 32'h0B);
        chk("sys_va", 32'(va_error), 32'd0);
        chk("sys_bad_va", bad_va, 32'd0);
        idle(); step();
        set_ins(32'h1c000320, 32'h0, 1'b0, 5'd0, 7'b1111111, 32'h00000555, 1'b1, 1'b0, 14'd0, 32'd0);
        step();
        chk("int_ecode", 32'(csr_ecode), 32'h00);
        chk("int_flush", 32'(excp_flush), 32'd1);
        idle(); step();

        // Forwarding: youngest dest-5 result on port 0, port 1 asks for r0.
        fwd_raddr = {5'd0, 5'd5};
        push_alu(32'h1c000400, 32'h0000000A, 5'd5); step();
        chk("fwd_a_hit", 32'(fwd_hit), 32'b01);
        chk("fwd_a_data", fwd_data[31:0], 32'h0000000A);
        push_alu(32'h1c000404, 32'h0000000B, 5'd5); step();
        chk("fwd_b_hit", 32'(fwd_hit), 32'b01);
        chk("fwd_b_data0", fwd_data[31:0], 32'h0000000B);
        chk("fwd_b_data1", fwd_data[63:32], 32'd0);
        // Entry with gr_we=0 to dest 5 must not hit.
        set_ins(32'h1c000408, 32'h0000000C, 1'b0, 5'd5, 7'd0, 32'd0, 1'b0, 1'b0, 14'd0, 32'd0);
        step();
        chk("fwd_nowe_hit", 32'(fwd_hit), 32'b00);
        idle(); step();
        fwd_raddr = 0;

        // Asynchronous reset in the middle of a burst.
        push_alu(32'h1c000500, 32'h51, 5'd9);  step();
        push_alu(32'h1c000504, 32'h52, 5'd10); step();
        push_alu(32'h1c000508, 32'h53, 5'd11); step();
        chk("pre_rst_occ", 32'(occupancy), 32'd1);
        #2 rst = 1;
        #1;
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_rf_we", 32'(rf_we), 32'd0);
        chk("arst_excp", 32'(excp_flush), 32'd0);
        chk("arst_ertn", 32'(ertn_flush), 32'd0);
        chk("arst_allowin", 32'(ws_allowin), 32'd1);
        chk("arst_dbg_pc", debug_wb_pc, 32'd0);
        exp_q.delete();
        idle();
        @(posedge clk);
        #1 rst = 0;
        step();
        chk("post_rst_occ", 32'(occupancy), 32'd0);

        push_alu(32'h1c000600, 32'h61, 5'd12); step();
        chk("post_rst_wdata", rf_wdata, 32'h61);
        idle(); step();
        step();
        chk("sb_final_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
